// File: rtl/rtc_apb_arb.sv
// Round-robin arbiter sharing the RTC APB slave between N_REQ APB requesters.
// One transfer at a time is replayed downstream; every output is registered.
module rtc_apb_arb #(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                          pclk,
  input  logic                          prst_n,
  input  logic [N_REQ*ADDR_W-1:0]       s_apb_paddr,
  input  logic [N_REQ-1:0]              s_apb_psel,
  input  logic [N_REQ-1:0]              s_apb_penable,
  input  logic [N_REQ-1:0]              s_apb_pwrite,
  input  logic [N_REQ*DATA_W-1:0]       s_apb_pwdata,
  input  logic [N_REQ*(DATA_W/8)-1:0]   s_apb_pstrb,
  output logic [N_REQ-1:0]              s_apb_pready,
  output logic [DATA_W-1:0]             s_apb_prdata,
  output logic [N_REQ-1:0]              s_apb_pslverr,
  output logic [ADDR_W-1:0]             m_apb_paddr,
  output logic                          m_apb_psel,
  output logic                          m_apb_penable,
  output logic                          m_apb_pwrite,
  output logic [DATA_W-1:0]             m_apb_pwdata,
  output logic [DATA_W/8-1:0]           m_apb_pstrb,
  input  logic                          m_apb_pready,
  input  logic [DATA_W-1:0]             m_apb_prdata,
  input  logic                          m_apb_pslverr,
  output logic                          busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int GNT_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [GNT_W-1:0] GNT_INIT = GNT_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [GNT_W-1:0]  grant_q, grant_d;
  logic [GNT_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drop_q, drop_d;

  logic [ADDR_W-1:0] m_paddr_q, m_paddr_d;
  logic              m_psel_q, m_psel_d;
  logic              m_penable_q, m_penable_d;
  logic              m_pwrite_q, m_pwrite_d;
  logic [DATA_W-1:0] m_pwdata_q, m_pwdata_d;
  logic [STRB_W-1:0] m_pstrb_q, m_pstrb_d;
  logic [N_REQ-1:0]  s_pready_q, s_pready_d;
  logic [DATA_W-1:0] s_prdata_q, s_prdata_d;
  logic [N_REQ-1:0]  s_pslverr_q, s_pslverr_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] req_addr  [N_REQ];
  logic [DATA_W-1:0] req_wdata [N_REQ];
  logic [STRB_W-1:0] req_strb  [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_req
    assign req_addr[g]  = s_apb_paddr[g*ADDR_W +: ADDR_W];
    assign req_wdata[g] = s_apb_pwdata[g*DATA_W +: DATA_W];
    assign req_strb[g]  = s_apb_pstrb[g*STRB_W +: STRB_W];
  end

  // Round-robin search: first pending index after last_grant, wrapping.
  logic             win_found;
  logic [GNT_W-1:0] win_idx;
  int               cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_found && s_apb_psel[GNT_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GNT_W'(cand);
      end
    end
  end

  logic timeout_hit;
  logic req_alive;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign req_alive   = s_apb_psel[grant_q] && s_apb_penable[grant_q] && !drop_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    drop_d       = drop_q;
    m_paddr_d    = m_paddr_q;
    m_psel_d     = m_psel_q;
    m_penable_d  = m_penable_q;
    m_pwrite_d   = m_pwrite_q;
    m_pwdata_d   = m_pwdata_q;
    m_pstrb_d    = m_pstrb_q;
    s_pready_d   = '0;
    s_prdata_d   = '0;
    s_pslverr_d  = '0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        drop_d = 1'b0;
        if (win_found) begin
          grant_d      = win_idx;
          last_grant_d = win_idx;
          m_paddr_d    = req_addr[win_idx];
          m_pwrite_d   = s_apb_pwrite[win_idx];
          m_pwdata_d   = req_wdata[win_idx];
          m_pstrb_d    = req_strb[win_idx];
          m_psel_d     = 1'b1;
          m_penable_d  = 1'b0;
          state_d      = S_SETUP;
        end
      end

      S_SETUP: begin
        m_penable_d = 1'b1;
        if (!s_apb_psel[grant_q]) drop_d = 1'b1;
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A slave response takes priority over a timeout in the same cycle.
        if (m_apb_pready) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          state_d     = S_RESP;
          if (req_alive) begin
            s_pready_d[grant_q]  = 1'b1;
            s_pslverr_d[grant_q] = m_apb_pslverr;
            s_prdata_d           = m_apb_prdata;
          end
        end else if (timeout_hit) begin
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          state_d     = S_RESP;
          if (req_alive) begin
            s_pready_d[grant_q]  = 1'b1;
            s_pslverr_d[grant_q] = 1'b1;
          end
        end else if (!s_apb_psel[grant_q]) begin
          drop_d = 1'b1;
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        m_psel_d    = 1'b0;
        m_penable_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GNT_INIT;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      m_paddr_q    <= '0;
      m_psel_q     <= 1'b0;
      m_penable_q  <= 1'b0;
      m_pwrite_q   <= 1'b0;
      m_pwdata_q   <= '0;
      m_pstrb_q    <= '0;
      s_pready_q   <= '0;
      s_prdata_q   <= '0;
      s_pslverr_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      m_paddr_q    <= m_paddr_d;
      m_psel_q     <= m_psel_d;
      m_penable_q  <= m_penable_d;
      m_pwrite_q   <= m_pwrite_d;
      m_pwdata_q   <= m_pwdata_d;
      m_pstrb_q    <= m_pstrb_d;
      s_pready_q   <= s_pready_d;
      s_prdata_q   <= s_prdata_d;
      s_pslverr_q  <= s_pslverr_d;
      busy_q       <= busy_d;
    end
  end

  assign m_apb_paddr   = m_paddr_q;
  assign m_apb_psel    = m_psel_q;
  assign m_apb_penable = m_penable_q;
  assign m_apb_pwrite  = m_pwrite_q;
  assign m_apb_pwdata  = m_pwdata_q;
  assign m_apb_pstrb   = m_pstrb_q;
  assign s_apb_pready  = s_pready_q;
  assign s_apb_prdata  = s_prdata_q;
  assign s_apb_pslverr = s_pslverr_q;
  assign busy          = busy_q;

endmodule

// File: doc/rtc_apb_arb.md
Name: rtc_apb_arb

Overview:
Round-robin APB arbiter that shares the single RTC APB slave (rtc_apb) between N_REQ APB requesters, e.g. the CPU and a boot/config sequencer. It accepts one transfer at a time, replays it on the downstream APB port and returns the registered response to the winning requester. An optional per-transfer timeout returns PSLVERR if the RTC never asserts PREADY.

Parameters:
N_REQ, 2, number of upstream requesters (2..8)
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (PSTRB width = DATA_W/8)
TIMEOUT, 256, maximum M_ACCESS cycles before abort; 0 = no timeout

Ports:
pclk  input  1  APB clock
prst_n  input  1  asynchronous active-low reset
s_apb_paddr  input  N_REQ*ADDR_W  requester addresses, requester i at slice i
s_apb_psel  input  N_REQ  requester PSEL
s_apb_penable  input  N_REQ  requester PENABLE
s_apb_pwrite  input  N_REQ  requester PWRITE
s_apb_pwdata  input  N_REQ*DATA_W  requester write data
s_apb_pstrb  input  N_REQ*DATA_W/8  requester byte strobes
s_apb_pready  output  N_REQ  requester PREADY
s_apb_prdata  output  DATA_W  read data, shared; valid for the requester whose pready is high
s_apb_pslverr  output  N_REQ  requester PSLVERR
m_apb_paddr  output  ADDR_W  to RTC
m_apb_psel  output  1  to RTC
m_apb_penable  output  1  to RTC
m_apb_pwrite  output  1  to RTC
m_apb_pwdata  output  DATA_W  to RTC
m_apb_pstrb  output  DATA_W/8  to RTC
m_apb_pready  input  1  from RTC
m_apb_prdata  input  DATA_W  from RTC
m_apb_pslverr  input  1  from RTC
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, prst_n low): state IDLE; all outputs 0; last_grant = N_REQ-1, so requester 0 wins the first tie; timeout counter 0.
- All outputs are registered. No combinational path from upstream to downstream.
- FSM: IDLE -> M_SETUP -> M_ACCESS -> RESP -> IDLE.
- IDLE: a request is pending when s_apb_psel[i]=1, in either phase. The winner is the first pending index after last_grant, searching upward with wrap. On a win: latch the winner's addr/write/wdata/strb, set grant=i and last_grant=i, and go to M_SETUP. With no request, stay in IDLE.
- M_SETUP (1 cycle): m_psel=1, m_penable=0, latched fields driven. Go to M_ACCESS.
- M_ACCESS: m_psel=1, m_penable=1; the counter increments each cycle.
  - When m_apb_pready=1: capture m_prdata and m_pslverr, drop m_psel/m_penable in the next cycle, and go to RESP.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without pready: abort. Drop m_psel, set prdata=0 and pslverr=1, and go to RESP.
- RESP (1 cycle):
  - s_apb_pready[grant]=1, s_apb_pslverr[grant] = captured error, s_apb_prdata = captured data (writes also return captured m_prdata).
  - Other pready bits stay 0. Go to IDLE. The counter clears.
- Non-granted requesters see pready=0 (wait states) until they win. Their requests stay pending, and they must hold their signals per APB.
- Minimum requester latency: setup cycle + 3 access cycles with a zero-wait RTC. Each RTC wait state adds 1 cycle.
- Back-to-back: IDLE lasts 1 cycle between grants. With both requesters asserting continuously, grants alternate 0,1,0,1.
- Requester drops psel while granted (protocol violation): the downstream transfer still completes, and RESP is suppressed for that requester (pready stays 0).
- Async reset mid-transfer: immediate IDLE, m_psel drops, and no response is given to any requester.

Test Plan:
- Single write, requester 0, addr 0x04, data 0x1234_5678, zero-wait RTC -> m_psel high for 2 cycles with matching fields; s_apb_pready[0] pulses in cycle 4 after s0 setup; pslverr=0.
- Single read, requester 1, addr 0x00, RTC returns 0xDEAD_BEEF after 2 wait states -> s_apb_prdata=0xDEAD_BEEF with s_apb_pready[1] on cycle 6; pready[0] stays 0.
- Both requesters assert psel in the same cycle after reset -> requester 0 is served first, then requester 1, then 0 again under continuous requests (strict alternation).
- RTC holds pready=0 with TIMEOUT=4 -> after 4 M_ACCESS cycles m_psel drops; the requester gets pready=1, pslverr=1, prdata=0.
- RTC returns pslverr=1 on a read -> forwarded only to the granted requester's pslverr bit for one cycle.
- Assert prst_n low during M_ACCESS -> all outputs 0 next edge-independent; after release, a fresh request from requester 1 completes normally with requester 0 still favoured on ties.
